// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline stage: control-bundle layout and payload record.
package id_ex_pkg;

    localparam int unsigned WB_W = 2;
    localparam int unsigned M_W  = 3;
    localparam int unsigned EX_W = 4;

    localparam int unsigned EX_LSB = 0;
    localparam int unsigned M_LSB  = EX_LSB + EX_W;
    localparam int unsigned WB_LSB = M_LSB + M_W;

    localparam int unsigned EX_REGDST_BIT = 3;
    localparam int unsigned EX_ALUOP_LSB  = 1;
    localparam int unsigned EX_ALUOP_W    = 2;
    localparam int unsigned EX_ALUSRC_BIT = 0;

    localparam int unsigned PL_CTRL_W = WB_W + M_W + EX_W;
    localparam int unsigned PL_DATA_W = 32;
    localparam int unsigned PL_REG_W  = 5;
    localparam int unsigned PL_NREG   = 3;

    // Field order matches the flat vector packed by id_ex_pipe (ctrl in the MSBs).
    typedef struct packed {
        logic [PL_CTRL_W-1:0]          ctrl;
        logic [PL_DATA_W-1:0]          pc;
        logic [PL_DATA_W-1:0]          rs_data;
        logic [PL_DATA_W-1:0]          rt_data;
        logic [PL_DATA_W-1:0]          imm;
        logic [PL_NREG*PL_REG_W-1:0]   regs;
    } id_ex_payload_t;

    function automatic int unsigned payload_width(input int unsigned ctrl_w,
                                                  input int unsigned data_w,
                                                  input int unsigned reg_w,
                                                  input int unsigned nreg);
        return ctrl_w + 4 * data_w + nreg * reg_w;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus payload register; clear wins over load, payload holds on clear.
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/id_ex_pipe.sv
// Handshaked ID/EX stage with flush-to-bubble, external stall and a saturating bubble counter.
// Define ID_EX_SKID_EN for a two-entry (skid) stage with a registered-path up_ready_o.
module id_ex_pipe
    import id_ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned NREG   = 3,
    parameter int unsigned CTRL_W = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   up_valid_i,
    output logic                   up_ready_o,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [CTRL_W-1:0]      ctrl_i,
    input  logic [DATA_W-1:0]      pc_i,
    input  logic [DATA_W-1:0]      rs_data_i,
    input  logic [DATA_W-1:0]      rt_data_i,
    input  logic [DATA_W-1:0]      imm_i,
    input  logic [NREG*REG_W-1:0]  regs_i,
    output logic                   dn_valid_o,
    input  logic                   dn_ready_i,
    output logic [CTRL_W-1:0]      ctrl_o,
    output logic [DATA_W-1:0]      pc_o,
    output logic [DATA_W-1:0]      rs_data_o,
    output logic [DATA_W-1:0]      rt_data_o,
    output logic [DATA_W-1:0]      imm_o,
    output logic [NREG*REG_W-1:0]  regs_o,
    output logic [CNT_W-1:0]       bubble_cnt_o
);

    localparam int unsigned PAYLOAD_W = payload_width(CTRL_W, DATA_W, REG_W, NREG);

    logic [PAYLOAD_W-1:0] w_in_data;
    logic [PAYLOAD_W-1:0] w_main_din;
    logic [PAYLOAD_W-1:0] w_main_data;
    logic [CTRL_W-1:0]    w_main_ctrl;
    logic                 w_main_valid;
    logic                 w_main_load;
    logic                 w_main_clear;
    logic                 w_accept;
    logic                 w_issue;
    logic [CNT_W-1:0]     r_bubble_cnt;

    assign w_in_data = {ctrl_i, pc_i, rs_data_i, rt_data_i, imm_i, regs_i};
    assign w_accept  = up_valid_i & up_ready_o;
    assign w_issue   = w_main_valid & dn_ready_i;

`ifdef ID_EX_SKID_EN
    logic                 w_skid_valid;
    logic                 w_skid_load;
    logic                 w_skid_clear;
    logic [PAYLOAD_W-1:0] w_skid_data;

    // Ready depends only on stall and the registered skid occupancy.
    assign up_ready_o   = ~stall_i & ~w_skid_valid;

    // Skid refills main on issue; otherwise an accept lands in main if main frees up or is empty.
    assign w_main_load  = (w_issue & w_skid_valid) | (w_accept & (~w_main_valid | w_issue));
    assign w_main_din   = w_skid_valid ? w_skid_data : w_in_data;
    assign w_main_clear = flush_i | (w_issue & ~w_main_load);
    assign w_skid_load  = w_accept & w_main_valid & ~w_issue;
    assign w_skid_clear = flush_i | (w_issue & w_skid_valid);

    pipe_slot #(.W(PAYLOAD_W)) u_skid (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );
`else
    assign up_ready_o   = ~stall_i & (~w_main_valid | dn_ready_i);
    assign w_main_load  = w_accept;
    assign w_main_din   = w_in_data;
    assign w_main_clear = flush_i | (w_issue & ~w_accept);
`endif

    pipe_slot #(.W(PAYLOAD_W)) u_main (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_din),
        .o_valid (w_main_valid),
        .o_data  (w_main_data)
    );

    assign {w_main_ctrl, pc_o, rs_data_o, rt_data_o, imm_o, regs_o} = w_main_data;
    assign dn_valid_o = w_main_valid;
    // EX must never see stale control on a bubble.
    assign ctrl_o     = w_main_valid ? w_main_ctrl : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bubble_cnt <= '0;
        end else if (dn_ready_i && !w_main_valid && !(&r_bubble_cnt)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed vector table, hand sequences and a queue-based reference model.
module tb_id_ex_pipe;
    import id_ex_pkg::*;

`ifdef ID_EX_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        up_valid_i, up_ready_o, stall_i, flush_i, dn_valid_o, dn_ready_i;
    logic [8:0]  ctrl_i, ctrl_o;
    logic [31:0] pc_i, rs_data_i, rt_data_i, imm_i, pc_o, rs_data_o, rt_data_o, imm_o;
    logic [14:0] regs_i, regs_o;
    logic [15:0] bubble_cnt_o;

    logic        s_ready, s_up_ready, s_dn_valid;
    logic [8:0]  s_ctrl;
    logic [31:0] s_pc, s_rs, s_rt, s_imm;
    logic [14:0] s_regs;
    logic [3:0]  s_cnt;

    int n_vec = 0;
    int n_err = 0;

    id_ex_payload_t q[$];
    id_ex_payload_t last_head;
    logic [15:0]    m_bub;

    always #5 clk = ~clk;

    id_ex_pipe u_dut (
        .clk_i(clk), .rst_i(rst_i), .up_valid_i(up_valid_i), .up_ready_o(up_ready_o),
        .stall_i(stall_i), .flush_i(flush_i), .ctrl_i(ctrl_i), .pc_i(pc_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .regs_i(regs_i),
        .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i), .ctrl_o(ctrl_o), .pc_o(pc_o),
        .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o), .regs_o(regs_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_pipe #(.CNT_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst_i), .up_valid_i(1'b0), .up_ready_o(s_up_ready),
        .stall_i(1'b0), .flush_i(1'b0), .ctrl_i(9'h0), .pc_i(32'h0),
        .rs_data_i(32'h0), .rt_data_i(32'h0), .imm_i(32'h0), .regs_i(15'h0),
        .dn_valid_o(s_dn_valid), .dn_ready_i(s_ready), .ctrl_o(s_ctrl), .pc_o(s_pc),
        .rs_data_o(s_rs), .rt_data_o(s_rt), .imm_o(s_imm), .regs_o(s_regs),
        .bubble_cnt_o(s_cnt)
    );

    typedef struct {
        logic        v, st, fl, rdy;
        logic [31:0] pc;
        logic [8:0]  ctrl;
        logic        e_rdy, e_dv;
        logic [31:0] e_pc;
        logic [8:0]  e_ctrl;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_ready(input logic st, input logic rdy);
        return !st && ((q.size() < DEPTH) || (DEPTH == 1 && rdy));
    endfunction

    function automatic id_ex_payload_t rand_payload();
        id_ex_payload_t p;
        p.ctrl    = 9'($urandom);
        p.pc      = $urandom;
        p.rs_data = $urandom;
        p.rt_data = $urandom;
        p.imm     = $urandom;
        p.regs    = 15'($urandom);
        return p;
    endfunction

    task automatic model_step(input logic v, input logic st, input logic fl, input logic rdy,
                              input logic r, input id_ex_payload_t p);
        if (rdy && q.size() == 0 && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
        if (fl) begin
            q.delete();
        end else begin
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (v && r) q.push_back(p);
        end
        if (q.size() > 0) last_head = q[0];
    endtask

    task automatic check_outputs();
        logic [8:0] ec;
        ec = (q.size() > 0) ? q[0].ctrl : 9'h0;
        chk("dn_valid", 64'(dn_valid_o), 64'(q.size() > 0));
        chk("ctrl", 64'(ctrl_o), 64'(ec));
        chk("pc", 64'(pc_o), 64'(last_head.pc));
        chk("rs_data", 64'(rs_data_o), 64'(last_head.rs_data));
        chk("rt_data", 64'(rt_data_o), 64'(last_head.rt_data));
        chk("imm", 64'(imm_o), 64'(last_head.imm));
        chk("regs", 64'(regs_o), 64'(last_head.regs));
        chk("bubble_cnt", 64'(bubble_cnt_o), 64'(m_bub));
    endtask

    // Called at a negedge: drive, check ready, clock, advance model, check outputs at next negedge.
    task automatic cycle(input logic v, input logic st, input logic fl, input logic rdy,
                         input id_ex_payload_t p, output logic rdy_seen);
        logic r;
        up_valid_i = v; stall_i = st; flush_i = fl; dn_ready_i = rdy;
        ctrl_i = p.ctrl; pc_i = p.pc; rs_data_i = p.rs_data; rt_data_i = p.rt_data;
        imm_i = p.imm; regs_i = p.regs;
        #1;
        r = m_ready(st, rdy);
        rdy_seen = up_ready_o;
        chk("up_ready", 64'(up_ready_o), 64'(r));
        @(posedge clk);
        model_step(v, st, fl, rdy, r, p);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        id_ex_payload_t p;
        logic           rs;
        int             acc;
        logic [15:0]    bub0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 9'h1A5, 1'b1, 1'b1, 32'h40, 9'h1A5};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 9'h011, 1'b0, 1'b1, 32'h40, 9'h1A5};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 9'h011, 1'b0, 1'b1, 32'h40, 9'h1A5};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 9'h011, 1'b0, 1'b1, 32'h40, 9'h1A5};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 9'h011, 1'b1, 1'b1, 32'h44, 9'h011};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h48, 9'h0FF, 1'b0, 1'b0, 32'h44, 9'h000};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h48, 9'h0FF, 1'b0, 1'b0, 32'h44, 9'h000};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h48, 9'h0FF, 1'b1, 1'b1, 32'h48, 9'h0FF};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h4C, 9'h155, 1'b1, 1'b0, 32'h48, 9'h000};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h50, 9'h0AA, 1'b1, 1'b0, 32'h48, 9'h000};

        rst_i = 1'b0; up_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; dn_ready_i = 1'b0;
        ctrl_i = '0; pc_i = '0; rs_data_i = '0; rt_data_i = '0; imm_i = '0; regs_i = '0;
        s_ready = 1'b0;
        last_head = '0; m_bub = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check_outputs();
        stall_i = 1'b1; #1;
        chk("reset_ready_stall", 64'(up_ready_o), 64'(0));
        stall_i = 1'b0; #1;
        chk("reset_ready", 64'(up_ready_o), 64'(1));
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            p = rand_payload();
            p.pc = tbl[i].pc;
            p.ctrl = tbl[i].ctrl;
            cycle(tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].rdy, p, rs);
`ifndef ID_EX_SKID_EN
            chk($sformatf("tbl%0d_up_ready", i), 64'(rs), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_dn_valid", i), 64'(dn_valid_o), 64'(tbl[i].e_dv));
            chk($sformatf("tbl%0d_pc", i), 64'(pc_o), 64'(tbl[i].e_pc));
            chk($sformatf("tbl%0d_ctrl", i), 64'(ctrl_o), 64'(tbl[i].e_ctrl));
`endif
        end

        // Back-to-back streaming of 8 instructions
        cycle(1'b0, 1'b0, 1'b1, 1'b1, rand_payload(), rs);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            p = rand_payload();
            p.pc = 32'h100 + 32'(4 * i);
            cycle(1'b1, 1'b0, 1'b0, 1'b1, p, rs);
            if (rs) acc++;
            chk("stream_pc", 64'(pc_o), 64'(32'h100 + 32'(4 * i)));
        end
        chk("stream_accepts", 64'(acc), 64'(8));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, rand_payload(), rs);

        // Stall: held entry issues, then bubbles
        cycle(1'b0, 1'b0, 1'b1, 1'b0, rand_payload(), rs);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_payload(), rs);
        bub0 = m_bub;
        cycle(1'b1, 1'b1, 1'b0, 1'b1, rand_payload(), rs);
        chk("stall_no_accept", 64'(rs), 64'(0));
        cycle(1'b1, 1'b1, 1'b0, 1'b1, rand_payload(), rs);
        chk("stall_bubble_ctrl", 64'(ctrl_o), 64'(0));
        cycle(1'b1, 1'b0, 1'b0, 1'b1, rand_payload(), rs);
        chk("stall_bubble_cnt", 64'(bubble_cnt_o), 64'(bub0 + 16'd2));

        // Randomized traffic against the queue model
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(3) != 0), ($urandom_range(6) == 0),
                  ($urandom_range(19) == 0), ($urandom_range(4) < 3), rand_payload(), rs);
        end

        // Asynchronous reset between edges while holding an entry
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_payload(), rs);
        chk("pre_reset_valid", 64'(dn_valid_o), 64'(1));
        #2;
        rst_i = 1'b0;
        #1;
        chk("async_rst_valid", 64'(dn_valid_o), 64'(0));
        chk("async_rst_ctrl", 64'(ctrl_o), 64'(0));
        chk("async_rst_pc", 64'(pc_o), 64'(0));
        chk("async_rst_cnt", 64'(bubble_cnt_o), 64'(0));
        q.delete(); last_head = '0; m_bub = '0;
        up_valid_i = 1'b0; dn_ready_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check_outputs();

        // Bubble counter saturation on a 4-bit instance
        s_ready = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            chk("sat_cnt", 64'(s_cnt), 64'((k < 15) ? k : 15));
        end
        s_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised, handshaked ID/EX pipeline stage for the 5-stage CPU. It replaces the fixed-width stall-only ID/EX latch. It carries the control bundle (WB/M/EX), PC, both operands, the immediate and NREG register indices from ID to EX. Flow uses valid/ready, with flush-to-bubble and external stall. Bubbles always present all-zero control to EX, and a saturating counter records consumed bubbles for the performance monitor.

## Interface
Parameters:
- DATA_W, 32, width of PC, operands, immediate
- REG_W, 5, register index width
- NREG, 3, number of register index fields (rs, rt, rd)
- CTRL_W, 9, control bundle width: WB[8:7], M[6:4], EX[3:0]
- CNT_W, 16, bubble counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- up_valid_i  in  1  ID presents an instruction
- up_ready_o  out  1  stage can accept
- stall_i  in  1  hazard-unit hold; blocks acceptance
- flush_i  in  1  squash stage contents (taken branch/jump)
- ctrl_i  in  CTRL_W  control bundle
- pc_i, rs_data_i, rt_data_i, imm_i  in  DATA_W each
- regs_i  in  NREG*REG_W  packed register indices, field 0 in LSBs
- dn_valid_o  out  1  EX-side instruction valid
- dn_ready_i  in  1  EX consumes
- ctrl_o  out  CTRL_W  control; 0 whenever dn_valid_o=0
- pc_o, rs_data_o, rt_data_o, imm_o  out  DATA_W each
- regs_o  out  NREG*REG_W
- bubble_cnt_o  out  CNT_W  consumed-bubble count

## Operation
- Accept: up_valid_i & up_ready_o at a rising edge.
- Issue: dn_valid_o & dn_ready_i at a rising edge.
- Default (depth 1): up_ready_o = ~stall_i & (~dn_valid_o | dn_ready_i). This path is combinational from dn_ready_i.
- On accept, all payload and ctrl are registered. dn_valid_o is 1 on the next cycle.
- On issue without a simultaneous accept, dn_valid_o goes to 0 and the payload holds its last value. ctrl_o reads 0 because it is gated.
- stall_i=1: no accept. The held entry may still issue; after issue the output is a bubble.
- flush_i=1: at the next edge every entry is invalidated, and an accept in the same cycle is discarded. flush has priority over accept, issue and stall. up_ready_o is not gated by flush.
- Bubble counter: increments at each edge where dn_ready_i=1 and dn_valid_o=0. It saturates at all-ones and is cleared only by reset.
- FIFO order is always preserved.

## Timing
- Latency is 1 cycle from accept to dn_valid_o.
- Throughput is 1 per cycle when dn_ready_i=1 and stall_i=0.
- Reset values:
  - dn_valid_o=0, ctrl_o=0, all data outputs 0, bubble_cnt_o=0
  - skid entry empty
  - up_ready_o = ~stall_i
- Reset asserted mid-transfer drops all contents immediately and asynchronously.
- When empty with dn_ready_i=0, the stage still accepts (up_ready_o=1).
- When full with dn_ready_i=0 (depth 1), up_ready_o=0.
- Flush with accept and issue in the same cycle: the issue completes, the accepted data is dropped, and the stage is empty next cycle.

## Configuration
- ID_EX_SKID_EN defined:
  - Adds a second (skid) entry, giving depth 2.
  - up_ready_o = ~stall_i & ~skid_full. It is a register output with no combinational path from dn_ready_i.
  - An accept while main is full and not issuing writes the skid entry.
  - On issue, skid moves to main in the same edge.
  - Flush clears both entries.
- ID_EX_SKID_EN undefined: depth 1, with up_ready_o as in Operation.

## Structure
- Package id_ex_pkg holds:
  - WB_W=2, M_W=3, EX_W=4 and the bit offsets of each control field
  - EX sub-field positions: RegDst[3], ALUOp[2:1], ALUSrc[0]
  - packed payload typedef id_ex_payload_t
- Sub-module pipe_slot: one valid bit plus payload register with load/clear. It is instantiated once, or twice under ID_EX_SKID_EN.
- The top level holds the handshake logic, ctrl gating and the bubble counter.

## Test plan
- Reset release, then up_valid_i=1 with pc_i=0x40 and ctrl_i=0x1A5, dn_ready_i=1 → the next cycle shows dn_valid_o=1, pc_o=0x40 and ctrl_o=0x1A5; back-to-back streaming of 8 instructions completes in 8 cycles.
- dn_ready_i=0 for 3 cycles while full → up_ready_o=0 (depth 1) and the outputs are stable. With ID_EX_SKID_EN, one extra accept occurs before up_ready_o=0, and order is preserved on release.
- stall_i=1 for 2 cycles with up_valid_i=1 → no accept. The held entry issues, then 2 bubbles follow: ctrl_o=0 and bubble_cnt_o increments by 2.
- flush_i=1 with up_valid_i=1 while full → next cycle dn_valid_o=0 and ctrl_o=0, and the flushed pc never appears.
- Force CNT_W=4, present 20 consumed bubbles → bubble_cnt_o=0xF and holds.
- Assert rst_i low mid-stream between clock edges → dn_valid_o=0 and ctrl_o=0 immediately, before the next edge.
